// File: rtl/mux2_checker.sv
// Checker for a 2:1 mux stage: recomputes the mux output, counts compares, failures,
// all-zero input samples and "i0 then i1" patterns. Optional one-cycle latency on y.
//
// Pattern FSM
//   state  | meaning
//   IDLE   | previous enabled sample did not have i0=1 (or none since en=0/clr/reset)
//   SAW_I0 | previous enabled sample had i0=1; i1=1 now completes the pattern
module mux2_checker #(
    parameter int CNT_W = 16,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             i0,
    input  logic             i1,
    input  logic             sel,
    input  logic             y,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] seq_cnt,
    output logic             seq_hit
);

    typedef enum logic {
        IDLE   = 1'b0,
        SAW_I0 = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   hit_d;

    logic   sample;
    logic   exp_now;
    logic   exp_q;
    logic   valid_q;
    logic   do_cmp;
    logic   cmp_exp;
    logic   fail;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // A clear edge discards its own sample, so it never counts as an enabled sample.
    always_comb begin
        sample  = en & ~clr;
        exp_now = sel ? i1 : i0;
        do_cmp  = (LAT == 0) ? sample : (sample & valid_q);
        cmp_exp = (LAT == 0) ? exp_now : exp_q;
        fail    = do_cmp & (y != cmp_exp);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (!sample) begin
            valid_q <= 1'b0;
        end else begin
            exp_q   <= exp_now;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any non-sampling edge (en=0 or clr) falls back to IDLE so patterns never span gaps.
    always_comb begin
        state_d = IDLE;
        hit_d   = 1'b0;
        if (sample) begin
            case (state_q)
                IDLE: begin
                    state_d = i0 ? SAW_I0 : IDLE;
                end
                SAW_I0: begin
                    hit_d   = i1;
                    state_d = i0 ? SAW_I0 : IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            seq_hit    <= 1'b0;
            chk_cnt    <= '0;
            err_cnt    <= '0;
            zero_cnt   <= '0;
            seq_cnt    <= '0;
        end else if (clr) begin
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            seq_hit    <= 1'b0;
            chk_cnt    <= '0;
            err_cnt    <= '0;
            zero_cnt   <= '0;
            seq_cnt    <= '0;
        end else begin
            mismatch <= fail;
            seq_hit  <= hit_d;
            if (fail) begin
                err_sticky <= 1'b1;
                err_cnt    <= sat_inc(err_cnt);
            end
            if (do_cmp) begin
                chk_cnt <= sat_inc(chk_cnt);
            end
            if (sample && !i0 && !i1) begin
                zero_cnt <= sat_inc(zero_cnt);
            end
            if (hit_d) begin
                seq_cnt <= sat_inc(seq_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mux2_checker.sv
// Scoreboard bench for mux2_checker: three instances (LAT=0, LAT=1, LAT=0 with 2-bit counters)
// share stimulus; a sample-history reference model predicts every registered output per edge.
module tb_mux2_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, en = 1'b0, clr = 1'b0, i0 = 1'b0, i1 = 1'b0, sel = 1'b0;
    logic y0 = 1'b0, y1 = 1'b0, y2 = 1'b0;
    logic yreg = 1'b0;

    // Registered mux feeding the LAT=1 instance.
    always @(posedge clk) yreg <= sel ? i1 : i0;

    logic        a_mm, a_st, a_hit;
    logic [15:0] a_chk, a_err, a_zero, a_seq;
    logic        b_mm, b_st, b_hit;
    logic [15:0] b_chk, b_err, b_zero, b_seq;
    logic        c_mm, c_st, c_hit;
    logic [1:0]  c_chk, c_err, c_zero, c_seq;

    mux2_checker #(.CNT_W(16), .LAT(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .i0(i0), .i1(i1), .sel(sel), .y(y0),
        .mismatch(a_mm), .err_sticky(a_st), .chk_cnt(a_chk), .err_cnt(a_err),
        .zero_cnt(a_zero), .seq_cnt(a_seq), .seq_hit(a_hit));

    mux2_checker #(.CNT_W(16), .LAT(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .i0(i0), .i1(i1), .sel(sel), .y(y1),
        .mismatch(b_mm), .err_sticky(b_st), .chk_cnt(b_chk), .err_cnt(b_err),
        .zero_cnt(b_zero), .seq_cnt(b_seq), .seq_hit(b_hit));

    mux2_checker #(.CNT_W(2), .LAT(0)) dut_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .i0(i0), .i1(i1), .sel(sel), .y(y2),
        .mismatch(c_mm), .err_sticky(c_st), .chk_cnt(c_chk), .err_cnt(c_err),
        .zero_cnt(c_zero), .seq_cnt(c_seq), .seq_hit(c_hit));

    typedef struct packed {
        logic        mm;
        logic        st;
        logic        hit;
        logic [31:0] chk;
        logic [31:0] err;
        logic [31:0] zero;
        logic [31:0] seq;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
        exp_t c;
    } row_t;

    row_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: counts plus a record of the previous enabled sample.
    int m_chk[3], m_err[3], m_zero[3], m_seq[3];
    bit m_st[3], m_mm[3], m_hit[3];
    bit pv[3], p_i0[3], p_exp[3];
    int lat[3]  = '{0, 1, 0};
    int maxv[3] = '{65535, 65535, 3};

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_clear(input int k);
        m_chk[k] = 0; m_err[k] = 0; m_zero[k] = 0; m_seq[k] = 0;
        m_st[k] = 0; pv[k] = 0;
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit a0, input bit a1,
                        input bit s, input bit f0, input bit f1, input bit f2);
        bit   ex;
        bit   yv[3];
        exp_t ev[3];
        row_t row;
        @(negedge clk);
        rst = r; en = e; clr = c; i0 = a0; i1 = a1; sel = s;
        ex = s ? a1 : a0;
        y0 = ex ^ f0;
        y1 = yreg ^ f1;
        y2 = ex ^ f2;
        yv[0] = y0; yv[1] = y1; yv[2] = y2;
        for (int k = 0; k < 3; k++) begin
            bit has_cmp;
            bit ref_v;
            m_mm[k]  = 0;
            m_hit[k] = 0;
            if (!r || c) begin
                model_clear(k);
            end else if (!e) begin
                pv[k] = 0;
            end else begin
                has_cmp = (lat[k] == 0) || pv[k];
                ref_v   = (lat[k] == 0) ? ex : p_exp[k];
                if (has_cmp) begin
                    m_chk[k] = sat(m_chk[k], maxv[k]);
                    if (yv[k] != ref_v) begin
                        m_err[k] = sat(m_err[k], maxv[k]);
                        m_mm[k]  = 1;
                        m_st[k]  = 1;
                    end
                end
                if (!a0 && !a1) m_zero[k] = sat(m_zero[k], maxv[k]);
                if (pv[k] && p_i0[k] && a1) begin
                    m_hit[k] = 1;
                    m_seq[k] = sat(m_seq[k], maxv[k]);
                end
                pv[k] = 1; p_i0[k] = a0; p_exp[k] = ex;
            end
            ev[k].mm = m_mm[k]; ev[k].st = m_st[k]; ev[k].hit = m_hit[k];
            ev[k].chk = m_chk[k]; ev[k].err = m_err[k];
            ev[k].zero = m_zero[k]; ev[k].seq = m_seq[k];
        end
        row.a = ev[0]; row.b = ev[1]; row.c = ev[2];
        sb.push_back(row);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge presents a new set of registered results.
    initial begin
        row_t r;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                r = sb.pop_front();
                cmp("a.mismatch", 32'(a_mm), 32'(r.a.mm));
                cmp("a.sticky",   32'(a_st), 32'(r.a.st));
                cmp("a.seq_hit",  32'(a_hit), 32'(r.a.hit));
                cmp("a.chk_cnt",  32'(a_chk), r.a.chk);
                cmp("a.err_cnt",  32'(a_err), r.a.err);
                cmp("a.zero_cnt", 32'(a_zero), r.a.zero);
                cmp("a.seq_cnt",  32'(a_seq), r.a.seq);
                cmp("b.mismatch", 32'(b_mm), 32'(r.b.mm));
                cmp("b.sticky",   32'(b_st), 32'(r.b.st));
                cmp("b.seq_hit",  32'(b_hit), 32'(r.b.hit));
                cmp("b.chk_cnt",  32'(b_chk), r.b.chk);
                cmp("b.err_cnt",  32'(b_err), r.b.err);
                cmp("b.zero_cnt", 32'(b_zero), r.b.zero);
                cmp("b.seq_cnt",  32'(b_seq), r.b.seq);
                cmp("c.mismatch", 32'(c_mm), 32'(r.c.mm));
                cmp("c.sticky",   32'(c_st), 32'(r.c.st));
                cmp("c.seq_hit",  32'(c_hit), 32'(r.c.hit));
                cmp("c.chk_cnt",  32'(c_chk), r.c.chk);
                cmp("c.err_cnt",  32'(c_err), r.c.err);
                cmp("c.zero_cnt", 32'(c_zero), r.c.zero);
                cmp("c.seq_cnt",  32'(c_seq), r.c.seq);
            end
        end
    end

    initial begin
        int b_mm_seen;
        bit pat_i0[6] = '{1, 1, 0, 0, 1, 0};
        bit pat_i1[6] = '{0, 1, 1, 1, 0, 1};
        for (int k = 0; k < 3; k++) model_clear(k);

        // Reset with random inputs, then idle with en=0.
        repeat (3) step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
        cmp("rst.a_chk", 32'(a_chk), 0);
        repeat (5) step(1, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
        cmp("idle.a_zero", 32'(a_zero), 0);

        // All 8 input combinations with a correct mux.
        for (int v = 0; v < 8; v++) step(1, 1, 0, v[2], v[1], v[0], 0, 0, 0);
        cmp("comb.a_chk", 32'(a_chk), 8);
        cmp("comb.a_err", 32'(a_err), 0);
        cmp("comb.a_zero", 32'(a_zero), 2);

        // Registered mux, 4th compare corrupted.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        b_mm_seen = 0;
        for (int n = 0; n < 10; n++) begin
            step(1, 1, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 0, (n == 4), 0);
            b_mm_seen += int'(b_mm);
        end
        cmp("lat1.b_chk", 32'(b_chk), 9);
        cmp("lat1.b_err", 32'(b_err), 1);
        cmp("lat1.b_mm_pulses", 32'(b_mm_seen), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cmp("lat1.b_sticky", 32'(b_st), 1);

        // Pattern detection across an en=0 gap.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 6; n++) begin
            if (n == 5) step(1, 0, 0, 1, 1, 0, 0, 0, 0);
            step(1, 1, 0, pat_i0[n], pat_i1[n], 0, 0, 0, 0);
            cmp("pat.a_hit", 32'(a_hit), 32'(n == 1 || n == 2));
        end
        cmp("pat.a_seq", 32'(a_seq), 2);

        // Saturation of 2-bit counters, then clr with a simultaneous mismatch.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (5) step(1, 1, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), 0, 0, 1);
        cmp("sat.c_err", 32'(c_err), 3);
        step(1, 1, 1, 1, 0, 0, 0, 0, 1);
        cmp("clr.c_err", 32'(c_err), 0);
        cmp("clr.c_sticky", 32'(c_st), 0);
        cmp("clr.c_mm", 32'(c_mm), 0);

        // Reset while a LAT=1 compare with a bad y is pending.
        step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 1, 1, 1, 1);
        cmp("mrst.b_mm", 32'(b_mm), 0);
        cmp("mrst.b_chk", 32'(b_chk), 0);
        step(1, 1, 0, 0, 1, 0, 0, 0, 0);
        cmp("mrst.a_hit", 32'(a_hit), 0);
        cmp("mrst.b_chk_after", 32'(b_chk), 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 29) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        cmp("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux2_checker.md
# mux2_checker

Synthesizable checker that sits directly downstream of the 2:1 mux stage, consuming the same `i0`, `i1`, `sel` inputs and the mux output `y`. It recomputes the expected output, flags and counts mismatches, and tracks two input-activity properties: cycles with neither data input high, and the two-cycle pattern "`i0`, then `i1` on the next sample". Its results are registered counters and flags that go to a status/debug readout, so the mux can be checked on silicon or in emulation without simulator assertions.

## Interface
- `CNT_W`, 16: width of every counter output (≥ 2).
- `LAT`, 0: mux output latency in cycles; 0 means `y` is combinational from the current inputs, 1 means `y` is registered (valid one cycle later). Only 0 and 1 are legal.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `en`  in  1  sample-enable; the checker observes inputs only on edges where `en`=1.
- `clr`  in  1  synchronous clear of counters and sticky flag.
- `i0`  in  1  mux data input 0.
- `i1`  in  1  mux data input 1.
- `sel`  in  1  mux select (0 → `i0`, 1 → `i1`).
- `y`  in  1  mux output under check.
- `mismatch`  out  1  one-cycle pulse: the last compare failed.
- `err_sticky`  out  1  set by any mismatch; held until `clr` or reset.
- `chk_cnt`  out  CNT_W  number of compares performed, saturating.
- `err_cnt`  out  CNT_W  number of failed compares, saturating.
- `zero_cnt`  out  CNT_W  sampled cycles with `i0`=0 and `i1`=0, saturating.
- `seq_cnt`  out  CNT_W  completed "`i0` then `i1`" patterns, saturating.
- `seq_hit`  out  1  one-cycle pulse when the pattern completes.

## Operation
- Expected value: `exp = sel ? i1 : i0`, computed from the sampled inputs.
- LAT=0: on an enabled edge, compare `y` with `exp` for the same sample.
- LAT=1: on an enabled edge, register `exp` and set a pipeline-valid bit. On the next enabled edge, if valid was set, compare the current `y` with the registered `exp`. The first enabled edge after reset, `clr`, or `en`=0 performs no compare.
- Compare: `chk_cnt` += 1; on inequality, `err_cnt` += 1, `mismatch` pulses, and `err_sticky` sets.
- `zero_cnt` += 1 on each enabled edge where `i0`=0 and `i1`=0.
- Pattern FSM, states IDLE and SAW_I0, overlapping detection:
  - From IDLE: go to SAW_I0 if `i0`=1, else stay in IDLE.
  - From SAW_I0: if `i1`=1, pulse `seq_hit` and increment `seq_cnt`. The next state is SAW_I0 if `i0`=1, else IDLE.
- `en`=0 edge:
  - No counter change, no pulses.
  - FSM returns to IDLE and the pipeline-valid bit clears, so a pattern or compare never spans a disabled cycle.
- Saturation: every counter stops at 2^CNT_W−1; `err_sticky` still sets.
- `clr`=1 (with `rst`=1):
  - All counters go to 0, `err_sticky` clears, FSM goes to IDLE, and valid clears.
  - That edge's sample is discarded, so `clr` takes priority over a simultaneous event.
- `rst`=0 overrides everything, including `clr` and `en`.

## Timing
- Reset values: `mismatch`=0, `err_sticky`=0, `seq_hit`=0, all counters 0, FSM IDLE, valid 0, stored `exp` 0.
- All outputs are registered. A result is visible after the edge at which the compare or detect occurs and persists one cycle (pulses) or until updated (counters).
- LAT=0: inputs sampled at edge k give a result visible after edge k.
- LAT=1: `exp` is captured at edge k, compared with `y` at edge k+1, and the result is visible after edge k+1.
- Pattern: `i0`=1 at edge k and `i1`=1 at edge k+1 (both enabled) give `seq_hit` after edge k+1.
- Reset mid-operation takes effect at the next edge. Any in-flight compare or pattern is dropped, and no pulse fires on that edge.

## Test plan
- Reset and idle (LAT=0): hold `rst`=0 for 3 cycles with random inputs. All outputs must be 0. Release `rst` with `en`=0 for 5 cycles; everything stays 0.
- Correct mux (LAT=0): drive a correct `y` for all 8 input combinations. Required: `chk_cnt`=8, `err_cnt`=0, `zero_cnt`=2, `mismatch` never asserted.
- Fault injection (LAT=1): drive correct, registered `y` for 10 enabled cycles, inverting `y` on the 4th compare only. Required: `chk_cnt`=9, `err_cnt`=1, `mismatch` high for exactly one cycle, `err_sticky`=1 thereafter.
- Pattern: drive `i0`,`i1` pairs (1,0),(1,1),(0,1),(0,1),(1,0),`en`=0 gap,(0,1). Required: `seq_cnt`=2, with `seq_hit` after the 2nd and 3rd samples only.
- Saturation and clear: with CNT_W=2, inject 5 mismatches. `err_cnt` must hold at 3. Then assert `clr` on the same edge as a mismatching sample: all counters 0, `err_sticky`=0, no `mismatch` pulse.
- Mid-run reset: assert `rst`=0 on the edge following `i0`=1 with an erroneous `y` pending under LAT=1. All outputs must be 0 afterwards. After release, `i1`=1 on the first sample gives no `seq_hit`.
